// File: rtl/cpc_uart_pkg.sv
// Shared types and constants for the CPC serial transmit path.
package cpc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Sized for the largest legal divider so one counter width serves every build.
    localparam int CLK_DIV_MAX = 65535;
    localparam int BAUD_W      = $clog2(CLK_DIV_MAX + 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLK_DIV clocks and flags the last clock of each bit.
module uart_baud_tick
    import cpc_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLK_DIV - 1);

    logic [BAUD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + BAUD_W'(1);
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte fifo and serialises each byte as an async frame on txd.
module fifo_uart_tx
    import cpc_uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifo_q,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       txd,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t  state, state_next;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       parity_bit, parity_next;
    logic       txd_next, read_next, busy_next, done_next;
    logic       bit_tick;
    logic       launch;

    assign launch = (state == IDLE) && enable && !fifo_empty;

    // The bit timer restarts on launch so the start bit gets a full period.
    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .clear   (reset | launch),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
            fifo_read  <= 1'b0;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            txd        <= txd_next;
            fifo_read  <= read_next;
            busy       <= busy_next;
            byte_done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = START;
            START:   if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && bit_cnt == LAST_DATA) begin
                    state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                end
            end
            PAR:     if (bit_tick) state_next = STOP;
            STOP:    if (bit_tick && bit_cnt == LAST_STOP) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: compute the level each output takes after this edge.
    always_comb begin
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        txd_next     = txd;
        read_next    = 1'b0;
        busy_next    = busy;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    shift_next   = fifo_q;
                    parity_next  = (^fifo_q[DATA_BITS-1:0]) ^ (PARITY == PAR_ODD);
                    bit_cnt_next = '0;
                    read_next    = 1'b1;
                    txd_next     = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                if (bit_tick) txd_next = shift[0];
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_next = '0;
                        txd_next     = (PARITY != PAR_NONE) ? parity_bit : 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shift_next   = shift >> 1;
                        txd_next     = shift[1];
                    end
                end
            end
            PAR: begin
                if (bit_tick) begin
                    bit_cnt_next = '0;
                    txd_next     = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        txd_next  = 1'b1;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four builds share a modelled pulse-then-release fifo.
module tb_fifo_uart_tx;

    localparam int BITLEN = 4;

    typedef struct {
        logic [1:0] inst;
        logic [7:0] data;
        bit         has_par;
        logic       par_bit;
        int         stops;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic [1:0] sel;
    logic [3:0] rd, tx, bz, dn;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops   = 0;
    logic       rd_any_d = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_q;

    int n_vec  = 0;
    int n_fail = 0;

    logic rd_s, tx_s, bz_s, dn_s;
    assign rd_s = rd[sel];
    assign tx_s = tx[sel];
    assign bz_s = bz[sel];
    assign dn_s = dn[sel];

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_q     = mem[rd_ptr[3:0]];

    // The fifo pops on the edge that ends the cycle after fifo_read falls.
    always @(posedge clk) begin
        rd_any_d <= |rd;
        if (rd_any_d && !(|rd)) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    fifo_uart_tx #(.CLK_DIV(BITLEN), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_read(rd[0]), .txd(tx[0]), .busy(bz[0]), .byte_done(dn[0]));
    fifo_uart_tx #(.CLK_DIV(BITLEN), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_even (
        .clk(clk), .reset(reset), .enable(en[1]), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_read(rd[1]), .txd(tx[1]), .busy(bz[1]), .byte_done(dn[1]));
    fifo_uart_tx #(.CLK_DIV(BITLEN), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_odd (
        .clk(clk), .reset(reset), .enable(en[2]), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_read(rd[2]), .txd(tx[2]), .busy(bz[2]), .byte_done(dn[2]));
    fifo_uart_tx #(.CLK_DIV(BITLEN), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_stop2 (
        .clk(clk), .reset(reset), .enable(en[3]), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_read(rd[3]), .txd(tx[3]), .busy(bz[3]), .byte_done(dn[3]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flushFifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic waitLaunch(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (rd_s === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("launch_seen", 32'(ok), 32'd1);
    endtask

    // Follows one frame clock by clock from the launch cycle through byte_done.
    task automatic checkFrame(input logic [7:0] data, input bit has_par, input logic par_bit,
                              input int stops, input int max_wait, input bit chk_empty,
                              input int drop_at);
        logic exp_bits [0:11];
        int   nb;
        bit   ok;
        logic exp_txd;
        nb = 0;
        exp_bits[nb] = 1'b0;
        nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
            exp_bits[nb] = data[i];
            nb = nb + 1;
        end
        if (has_par) begin
            exp_bits[nb] = par_bit;
            nb = nb + 1;
        end
        for (int i = 0; i < stops; i++) begin
            exp_bits[nb] = 1'b1;
            nb = nb + 1;
        end
        waitLaunch(max_wait, ok);
        if (!ok) return;
        for (int k = 0; k <= nb * BITLEN; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_at) en = '0;
            exp_txd = (k < nb * BITLEN) ? exp_bits[k / BITLEN] : 1'b1;
            checkOutput($sformatf("txd k=%0d d=%0h", k, data), 32'(tx_s), 32'(exp_txd));
            checkOutput($sformatf("fifo_read k=%0d", k), 32'(rd_s), 32'(k == 0));
            checkOutput($sformatf("busy k=%0d", k), 32'(bz_s), 32'(k < nb * BITLEN));
            checkOutput($sformatf("byte_done k=%0d", k), 32'(dn_s), 32'(k == nb * BITLEN));
            if (chk_empty && k == 3) checkOutput("fifo_empty_k3", 32'(fifo_empty), 32'd1);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int p0;
        flushFifo();
        pushByte(v.data);
        sel = v.inst;
        en = '0;
        en[v.inst] = 1'b1;
        p0 = pops;
        checkFrame(v.data, v.has_par, v.par_bit, v.stops, 3, 1'b1, -1);
        en = '0;
        checkOutput("pop_count", 32'(pops), 32'(p0 + 1));
    endtask

    task automatic idleWatch(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s read i=%0d", name, i), 32'(rd_s), 32'd0);
            checkOutput($sformatf("%s txd i=%0d", name, i), 32'(tx_s), 32'd1);
            checkOutput($sformatf("%s done i=%0d", name, i), 32'(dn_s), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [0:10];
        bit   ok;
        int   p0;

        vecs[0]  = '{2'd0, 8'h55, 1'b0, 1'b0, 1};
        vecs[1]  = '{2'd0, 8'h01, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'd0, 8'h80, 1'b0, 1'b0, 1};
        vecs[3]  = '{2'd0, 8'hFF, 1'b0, 1'b0, 1};
        vecs[4]  = '{2'd1, 8'h07, 1'b1, 1'b1, 1};
        vecs[5]  = '{2'd2, 8'h07, 1'b1, 1'b0, 1};
        vecs[6]  = '{2'd3, 8'hA3, 1'b0, 1'b0, 2};
        vecs[7]  = '{2'd1, 8'h00, 1'b1, 1'b0, 1};
        vecs[8]  = '{2'd2, 8'h00, 1'b1, 1'b1, 1};
        vecs[9]  = '{2'd1, 8'h13, 1'b1, 1'b1, 1};
        vecs[10] = '{2'd2, 8'h13, 1'b1, 1'b0, 1};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        reset = 1'b1;
        en    = '0;
        sel   = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset txd", 32'(tx), 32'hF);
        checkOutput("reset fifo_read", 32'(rd), 32'h0);
        checkOutput("reset busy", 32'(bz), 32'h0);
        checkOutput("reset byte_done", 32'(dn), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i <= 10; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
        end

        $display("[TB] back-to-back frames");
        flushFifo();
        pushByte(8'h01);
        pushByte(8'h80);
        pushByte(8'hFF);
        sel = 2'd0;
        en  = 4'b0001;
        p0  = pops;
        checkFrame(8'h01, 1'b0, 1'b0, 1, 3, 1'b0, -1);
        checkFrame(8'h80, 1'b0, 1'b0, 1, 1, 1'b0, -1);
        checkFrame(8'hFF, 1'b0, 1'b0, 1, 1, 1'b0, -1);
        en = '0;
        repeat (3) @(negedge clk);
        checkOutput("b2b pops", 32'(pops), 32'(p0 + 3));
        checkOutput("b2b empty", 32'(fifo_empty), 32'd1);

        $display("[TB] enable low with data waiting, then drop enable mid-frame");
        flushFifo();
        pushByte(8'hAA);
        pushByte(8'h3C);
        p0 = pops;
        idleWatch(20, "en0");
        checkOutput("en0 pops", 32'(pops), 32'(p0));
        en = 4'b0001;
        checkFrame(8'hAA, 1'b0, 1'b0, 1, 3, 1'b0, 10);
        idleWatch(20, "drop");
        checkOutput("drop pops", 32'(pops), 32'(p0 + 1));
        checkOutput("drop not empty", 32'(fifo_empty), 32'd0);

        $display("[TB] reset during data bits");
        flushFifo();
        pushByte(8'h5A);
        en = 4'b0001;
        waitLaunch(3, ok);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        en    = '0;
        @(negedge clk);
        checkOutput("rst_data txd", 32'(tx_s), 32'd1);
        checkOutput("rst_data busy", 32'(bz_s), 32'd0);
        checkOutput("rst_data done", 32'(dn_s), 32'd0);
        reset = 1'b0;
        idleWatch(50, "after_rst");

        $display("[TB] reset during fifo_read");
        flushFifo();
        pushByte(8'h3C);
        en = 4'b0001;
        waitLaunch(3, ok);
        reset = 1'b1;
        en    = '0;
        @(negedge clk);
        checkOutput("rst_read fifo_read", 32'(rd_s), 32'd0);
        checkOutput("rst_read txd", 32'(tx_s), 32'd1);
        checkOutput("rst_read busy", 32'(bz_s), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_read pop done", 32'(fifo_empty), 32'd1);
        pushByte(8'hC3);
        en = 4'b0001;
        checkFrame(8'hC3, 1'b0, 1'b0, 1, 3, 1'b1, -1);
        en = '0;

        $display("[TB] empty fifo with enable high");
        flushFifo();
        en = 4'b0001;
        idleWatch(100, "empty");
        en = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
